// File: rtl/pbl_rolhas_pkg.sv
// Shared defaults and FSM encoding for the main cork buffer.
// Used by modulo_buffer_principal_rolhas (optional feature: PBL_ROLHAS_STARVE_EN).
package pbl_rolhas_pkg;

    localparam int DEF_WIDTH         = 7;
    localparam int DEF_CAPACITY      = 99;
    localparam int DEF_MIN_LEVEL     = 5;
    localparam int DEF_STARVE_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DS_ACK = 2'b01,
        ST_TR_ACK = 2'b10
    } state_e;

endpackage

// File: rtl/modulo_resposta_handshake.sv
// Four-phase responder for one channel: raises ack on grant,
// drops it once req is seen low (done pulses on that cycle).
module modulo_resposta_handshake (
    input  logic clk,
    input  logic clr,
    input  logic req,
    input  logic grant,
    output logic ack,
    output logic done
);

    logic ack_q;
    logic ack_d;

    assign done = ack_q & ~req;
    assign ack  = ack_q;

    always_comb begin
        ack_d = ack_q;
        if (grant) begin
            ack_d = 1'b1;
        end else if (done) begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

endmodule

// File: rtl/modulo_buffer_principal_rolhas.sv
// Main cork buffer: arbitrates transfer-in vs dispense-out handshakes.
// Define PBL_ROLHAS_STARVE_EN to add the sticky starvation flag starve_err.
module modulo_buffer_principal_rolhas
    import pbl_rolhas_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int CAPACITY      = DEF_CAPACITY,
    parameter int MIN_LEVEL     = DEF_MIN_LEVEL,
    parameter int STARVE_CYCLES = DEF_STARVE_CYCLES
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tr_req,
    output logic             tr_ack,
    input  logic             ds_req,
    output logic             ds_ack,
    output logic [WIDTH-1:0] reg_r,
    output logic             ro,
    output logic             min_signal,
    output logic             full
`ifdef PBL_ROLHAS_STARVE_EN
    ,
    output logic             starve_err
`endif
);

    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_LEVEL);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             grant_ds;
    logic             grant_tr;
    logic             done_ds;
    logic             done_tr;

    modulo_resposta_handshake u_hs_ds (
        .clk   (clk),
        .clr   (clr),
        .req   (ds_req),
        .grant (grant_ds),
        .ack   (ds_ack),
        .done  (done_ds)
    );

    modulo_resposta_handshake u_hs_tr (
        .clk   (clk),
        .clr   (clr),
        .req   (tr_req),
        .grant (grant_tr),
        .ack   (tr_ack),
        .done  (done_tr)
    );

    // Dispense has priority; empty/full block their channel without wrap.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        grant_ds = 1'b0;
        grant_tr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ds_req && (count_q != '0)) begin
                    grant_ds = 1'b1;
                    count_d  = count_q - ONE_W;
                    state_d  = ST_DS_ACK;
                end else if (tr_req && (count_q != CAP_W)) begin
                    grant_tr = 1'b1;
                    count_d  = count_q + ONE_W;
                    state_d  = ST_TR_ACK;
                end
            end
            ST_DS_ACK: begin
                if (done_ds) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TR_ACK: begin
                if (done_tr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign reg_r      = count_q;
    assign ro         = (count_q == '0);
    assign min_signal = (count_q < MIN_W);
    assign full       = (count_q == CAP_W);

`ifdef PBL_ROLHAS_STARVE_EN
    localparam logic [7:0] STARVE_W = 8'(STARVE_CYCLES);

    logic [7:0] starve_cnt_q;
    logic [7:0] starve_cnt_d;
    logic       starve_err_q;
    logic       starve_err_d;

    // Counter saturates at the threshold; the flag only clears on clr.
    always_comb begin
        starve_cnt_d = '0;
        starve_err_d = starve_err_q;
        if ((state_q == ST_IDLE) && ds_req && (count_q == '0)) begin
            if (starve_cnt_q == STARVE_W) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end
        if (starve_cnt_q == STARVE_W) begin
            starve_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            starve_cnt_q <= '0;
            starve_err_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_err_q <= starve_err_d;
        end
    end

    assign starve_err = starve_err_q;
`endif

endmodule

// File: tb/tb_modulo_buffer_principal_rolhas.sv
// Directed, table-driven bench for the main cork buffer.
// Works with or without PBL_ROLHAS_STARVE_EN.
module tb_modulo_buffer_principal_rolhas;

    logic       clk;
    logic       clr;
    logic       tr_req;
    logic       tr_ack;
    logic       ds_req;
    logic       ds_ack;
    logic [6:0] reg_r;
    logic       ro;
    logic       min_signal;
    logic       full;
`ifdef PBL_ROLHAS_STARVE_EN
    logic       starve_err;
`endif

    int errors = 0;
    int checks = 0;

    modulo_buffer_principal_rolhas dut (
        .clk        (clk),
        .clr        (clr),
        .tr_req     (tr_req),
        .tr_ack     (tr_ack),
        .ds_req     (ds_req),
        .ds_ack     (ds_ack),
        .reg_r      (reg_r),
        .ro         (ro),
        .min_signal (min_signal),
        .full       (full)
`ifdef PBL_ROLHAS_STARVE_EN
        ,
        .starve_err (starve_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       tr;
        logic       ds;
        logic       e_tr_ack;
        logic       e_ds_ack;
        logic [6:0] e_cnt;
        logic       e_ro;
        logic       e_min;
        logic       e_full;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer_in(input string tag);
        tr_req = 1'b1;
        step();
        chk({tag, " tr_ack up"}, tr_ack, 1);
        tr_req = 1'b0;
        step();
        chk({tag, " tr_ack down"}, tr_ack, 0);
    endtask

    task automatic xfer_out(input string tag);
        ds_req = 1'b1;
        step();
        chk({tag, " ds_ack up"}, ds_ack, 1);
        ds_req = 1'b0;
        step();
        chk({tag, " ds_ack down"}, ds_ack, 0);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #3;
        clr = 1'b1;
        step();
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd1, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 1'b1, 1'b1, 1'b0};

        tr_req = 1'b0;
        ds_req = 1'b0;
        clr    = 1'b0;
        #12;
        chk("rst reg_r", reg_r, 0);
        chk("rst ro", ro, 1);
        chk("rst min", min_signal, 1);
        chk("rst full", full, 0);
        chk("rst acks", {tr_ack, ds_ack}, 0);
`ifdef PBL_ROLHAS_STARVE_EN
        chk("rst starve", starve_err, 0);
`endif
        clr = 1'b1;
        step();

        // Empty with both pending, then priority/handshake walk.
        foreach (vt[i]) begin
            tr_req = vt[i].tr;
            ds_req = vt[i].ds;
            step();
            chk($sformatf("vec%0d tr_ack", i), tr_ack, vt[i].e_tr_ack);
            chk($sformatf("vec%0d ds_ack", i), ds_ack, vt[i].e_ds_ack);
            chk($sformatf("vec%0d reg_r", i), reg_r, vt[i].e_cnt);
            chk($sformatf("vec%0d ro", i), ro, vt[i].e_ro);
            chk($sformatf("vec%0d min", i), min_signal, vt[i].e_min);
            chk($sformatf("vec%0d full", i), full, vt[i].e_full);
        end
        ds_req = 1'b0;
        step();
        chk("vec end ds_ack", ds_ack, 0);

        // Reset mid-handshake.
        xfer_in("pre");
        tr_req = 1'b1;
        step();
        chk("mid tr_ack", tr_ack, 1);
        chk("mid reg_r", reg_r, 2);
        #2;
        clr = 1'b0;
        #1;
        chk("arst tr_ack", tr_ack, 0);
        chk("arst ds_ack", ds_ack, 0);
        chk("arst reg_r", reg_r, 0);
        chk("arst ro", ro, 1);
        chk("arst min", min_signal, 1);
        chk("arst full", full, 0);
        tr_req = 1'b0;
        #3;
        clr = 1'b1;
        step();

        // 20 transfers from empty.
        for (int i = 0; i < 20; i++) xfer_in($sformatf("t20_%0d", i));
        chk("t20 reg_r", reg_r, 20);
        chk("t20 ro", ro, 0);
        chk("t20 min", min_signal, 0);

        // Down to 5, then cross the min threshold.
        for (int i = 0; i < 15; i++) xfer_out($sformatf("d15_%0d", i));
        chk("c5 reg_r", reg_r, 5);
        chk("c5 min", min_signal, 0);
        ds_req = 1'b1;
        step();
        chk("c5 ds_ack", ds_ack, 1);
        chk("c5 reg_r after", reg_r, 4);
        chk("c5 min after", min_signal, 1);
        ds_req = 1'b0;
        step();

        // Simultaneous requests at count 10.
        for (int i = 0; i < 6; i++) xfer_in($sformatf("to10_%0d", i));
        chk("c10 reg_r", reg_r, 10);
        ds_req = 1'b1;
        tr_req = 1'b1;
        step();
        chk("sim ds_ack", ds_ack, 1);
        chk("sim tr_ack", tr_ack, 0);
        chk("sim reg_r", reg_r, 9);
        ds_req = 1'b0;
        step();
        chk("sim ds_ack down", ds_ack, 0);
        chk("sim tr_ack wait", tr_ack, 0);
        step();
        chk("sim tr_ack up", tr_ack, 1);
        chk("sim reg_r 10", reg_r, 10);
        tr_req = 1'b0;
        step();

        // Fill to capacity and hold tr_req.
        for (int i = 0; i < 89; i++) xfer_in($sformatf("fill_%0d", i));
        chk("full reg_r", reg_r, 99);
        chk("full flag", full, 1);
        tr_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk($sformatf("full hold %0d", i), tr_ack, 0);
        end
        chk("full hold reg_r", reg_r, 99);
        tr_req = 1'b0;
        xfer_out("unfull");
        chk("unfull reg_r", reg_r, 98);
        chk("unfull flag", full, 0);

        // Starvation at empty.
        do_reset();
        ds_req = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
            chk($sformatf("starve ds_ack %0d", i), ds_ack, 0);
`ifdef PBL_ROLHAS_STARVE_EN
            if (i == 250) chk("starve early", starve_err, 0);
`endif
        end
        chk("starve ro", ro, 1);
`ifdef PBL_ROLHAS_STARVE_EN
        chk("starve set", starve_err, 1);
        ds_req = 1'b0;
        step();
        step();
        chk("starve sticky", starve_err, 1);
        clr = 1'b0;
        #1;
        chk("starve clr", starve_err, 0);
        clr = 1'b1;
`else
        ds_req = 1'b0;
`endif
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
